// File: rtl/uart_pkg.sv
// Shared constants, FSM encodings and the parity helper for the UART core.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH
  } rx_state_t;

  // Narrower frames are zero-extended by the caller, which leaves the XOR unchanged.
  function automatic logic parity_bit(input logic [7:0] data, input int mode);
    return (^data) ^ (mode == PARITY_ODD);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with first-word fall-through head and occupancy level.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push onto a full FIFO still lands.
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_core_param.sv
// Full-duplex UART: runtime baud tick, 16x-oversampled RX, TX/RX FIFOs, sticky error flags.
module uart_core_param
  import uart_pkg::*;
#(
  parameter int DIV_W      = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [DIV_W-1:0]              baud_div,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx_out,
  output logic                          tx_busy,
  input  logic                          rx_in,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          rx_parity_err,
  output logic                          rx_frame_err,
  output logic                          rx_overrun,
  input  logic                          err_clr,
  output logic [$clog2(FIFO_DEPTH):0]   tx_level,
  output logic [$clog2(FIFO_DEPTH):0]   rx_level
);

  localparam int OW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [OW-1:0] OS_LAST   = OW'(OVERSAMPLE - 1);
  localparam logic [OW-1:0] OS_MID    = OW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_q;
  logic             tick;

  assign tick = (div_cnt == div_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
      div_q   <= '0;
    end else if (tick) begin
      div_cnt <= '0;
      div_q   <= baud_div;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  logic                 tx_pop, tx_full, tx_empty, tx_load, tx_bit_end;
  logic [DATA_BITS-1:0] tx_head;
  tx_state_t            tx_state, tx_state_nxt;
  logic [OW-1:0]        tx_os, tx_os_nxt;
  logic [BW-1:0]        tx_bit, tx_bit_nxt;
  logic [DATA_BITS-1:0] tx_shift, tx_shift_nxt;
  logic                 tx_par, tx_par_nxt, tx_out_nxt;

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .reset_n(reset_n), .push(tx_valid && tx_ready), .push_data(tx_data),
    .pop(tx_pop), .head(tx_head), .full(tx_full), .empty(tx_empty), .level(tx_level)
  );

  assign tx_ready   = !tx_full;
  assign tx_busy    = (tx_state != TX_IDLE) || !tx_empty;
  assign tx_bit_end = tick && (tx_os == OS_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state <= TX_IDLE;
      tx_os    <= '0;
      tx_bit   <= '0;
      tx_out   <= 1'b1;
    end else begin
      tx_state <= tx_state_nxt;
      tx_os    <= tx_os_nxt;
      tx_bit   <= tx_bit_nxt;
      tx_out   <= tx_out_nxt;
    end
  end

  always_ff @(posedge clk) begin
    tx_shift <= tx_shift_nxt;
    tx_par   <= tx_par_nxt;
  end

  always_comb begin
    tx_state_nxt = tx_state;
    tx_os_nxt    = tx_os;
    tx_bit_nxt   = tx_bit;
    tx_shift_nxt = tx_shift;
    tx_par_nxt   = tx_par;
    tx_out_nxt   = tx_out;
    tx_pop       = 1'b0;
    tx_load      = 1'b0;
    if (tick && tx_state != TX_IDLE) tx_os_nxt = tx_bit_end ? '0 : tx_os + 1'b1;
    case (tx_state)
      TX_IDLE:   if (tick && !tx_empty) tx_load = 1'b1;
      TX_START:  if (tx_bit_end) begin
        tx_out_nxt   = tx_shift[0];
        tx_shift_nxt = tx_shift >> 1;
        tx_bit_nxt   = '0;
        tx_state_nxt = TX_DATA;
      end
      TX_DATA:   if (tx_bit_end) begin
        if (tx_bit == DATA_LAST) begin
          tx_bit_nxt = '0;
          if (PARITY != PARITY_NONE) begin
            tx_out_nxt   = tx_par;
            tx_state_nxt = TX_PARITY;
          end else begin
            tx_out_nxt   = 1'b1;
            tx_state_nxt = TX_STOP;
          end
        end else begin
          tx_out_nxt   = tx_shift[0];
          tx_shift_nxt = tx_shift >> 1;
          tx_bit_nxt   = tx_bit + 1'b1;
        end
      end
      TX_PARITY: if (tx_bit_end) begin
        tx_out_nxt   = 1'b1;
        tx_state_nxt = TX_STOP;
      end
      // Chaining straight into the next start bit keeps back-to-back frames gapless.
      TX_STOP:   if (tx_bit_end) begin
        if (tx_bit != STOP_LAST) tx_bit_nxt = tx_bit + 1'b1;
        else if (!tx_empty)      tx_load = 1'b1;
        else                     tx_state_nxt = TX_IDLE;
      end
      default:   tx_state_nxt = TX_IDLE;
    endcase
    if (tx_load) begin
      tx_pop       = 1'b1;
      tx_shift_nxt = tx_head;
      tx_par_nxt   = parity_bit(8'(tx_head), PARITY);
      tx_out_nxt   = 1'b0;
      tx_os_nxt    = '0;
      tx_state_nxt = TX_START;
    end
  end

  logic                 rx_meta, rx_s, rx_sample, rx_push, rx_pop, rx_full, rx_empty;
  logic                 par_set, frame_set, overrun_set;
  rx_state_t            rx_state, rx_state_nxt;
  logic [OW-1:0]        rx_os, rx_os_nxt;
  logic [BW-1:0]        rx_bit, rx_bit_nxt;
  logic [DATA_BITS-1:0] rx_shift, rx_shift_nxt;

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .reset_n(reset_n), .push(rx_push), .push_data(rx_shift),
    .pop(rx_pop), .head(rx_data), .full(rx_full), .empty(rx_empty), .level(rx_level)
  );

  assign rx_valid    = !rx_empty;
  assign rx_pop      = rx_valid && rx_ready;
  assign overrun_set = rx_push && rx_full && !rx_pop;
  // Start is checked half a bit in; every later sample is one full bit after the previous.
  assign rx_sample   = tick && (rx_os == ((rx_state == RX_START) ? OS_MID : OS_LAST));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta       <= 1'b1;
      rx_s          <= 1'b1;
      rx_state      <= RX_IDLE;
      rx_os         <= '0;
      rx_bit        <= '0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      rx_meta       <= rx_in;
      rx_s          <= rx_meta;
      rx_state      <= rx_state_nxt;
      rx_os         <= rx_os_nxt;
      rx_bit        <= rx_bit_nxt;
      rx_parity_err <= par_set     ? 1'b1 : (err_clr ? 1'b0 : rx_parity_err);
      rx_frame_err  <= frame_set   ? 1'b1 : (err_clr ? 1'b0 : rx_frame_err);
      rx_overrun    <= overrun_set ? 1'b1 : (err_clr ? 1'b0 : rx_overrun);
    end
  end

  always_ff @(posedge clk) begin
    rx_shift <= rx_shift_nxt;
  end

  always_comb begin
    rx_state_nxt = rx_state;
    rx_os_nxt    = rx_os;
    rx_bit_nxt   = rx_bit;
    rx_shift_nxt = rx_shift;
    rx_push      = 1'b0;
    par_set      = 1'b0;
    frame_set    = 1'b0;
    if (tick && rx_state != RX_IDLE && rx_state != RX_WAIT_HIGH)
      rx_os_nxt = rx_sample ? '0 : rx_os + 1'b1;
    case (rx_state)
      RX_IDLE:      if (tick && !rx_s) begin
        rx_os_nxt    = '0;
        rx_state_nxt = RX_START;
      end
      RX_START:     if (rx_sample) begin
        rx_bit_nxt   = '0;
        rx_state_nxt = rx_s ? RX_IDLE : RX_DATA;
      end
      RX_DATA:      if (rx_sample) begin
        rx_shift_nxt = {rx_s, rx_shift[DATA_BITS-1:1]};
        rx_bit_nxt   = rx_bit + 1'b1;
        if (rx_bit == DATA_LAST) rx_state_nxt = (PARITY != PARITY_NONE) ? RX_PARITY : RX_STOP;
      end
      RX_PARITY:    if (rx_sample) begin
        par_set      = (rx_s != parity_bit(8'(rx_shift), PARITY));
        rx_state_nxt = RX_STOP;
      end
      RX_STOP:      if (rx_sample) begin
        if (rx_s) begin
          rx_push      = 1'b1;
          rx_state_nxt = RX_IDLE;
        end else begin
          frame_set    = 1'b1;
          rx_state_nxt = RX_WAIT_HIGH;
        end
      end
      RX_WAIT_HIGH: if (rx_s) rx_state_nxt = RX_IDLE;
      default:      rx_state_nxt = RX_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_core_param.sv
// Randomised self-checking bench for uart_core_param: 8N1 instance plus an even-parity instance.
module tb_uart_core_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n = 1'b0;

  logic [15:0] baud_div;
  logic [7:0]  tx_data, rx_data;
  logic        tx_valid, tx_ready, tx_out, tx_busy, rx_in, rx_drv, loop;
  logic        rx_valid, rx_ready, rx_parity_err, rx_frame_err, rx_overrun, err_clr;
  logic [4:0]  tx_level, rx_level;

  logic [15:0] p_baud_div;
  logic [7:0]  p_tx_data, p_rx_data;
  logic        p_tx_valid, p_tx_ready, p_tx_out, p_tx_busy, p_rx_in, p_rx_drv, p_loop;
  logic        p_rx_valid, p_rx_ready, p_rx_parity_err, p_rx_frame_err, p_rx_overrun, p_err_clr;
  logic [4:0]  p_tx_level, p_rx_level;

  assign rx_in   = loop   ? tx_out   : rx_drv;
  assign p_rx_in = p_loop ? p_tx_out : p_rx_drv;

  uart_core_param dut (
    .clk(clk), .reset_n(reset_n), .baud_div(baud_div),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_out(tx_out), .tx_busy(tx_busy),
    .rx_in(rx_in), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err), .rx_overrun(rx_overrun),
    .err_clr(err_clr), .tx_level(tx_level), .rx_level(rx_level)
  );

  uart_core_param #(.PARITY(1)) dut_p (
    .clk(clk), .reset_n(reset_n), .baud_div(p_baud_div),
    .tx_data(p_tx_data), .tx_valid(p_tx_valid), .tx_ready(p_tx_ready), .tx_out(p_tx_out), .tx_busy(p_tx_busy),
    .rx_in(p_rx_in), .rx_data(p_rx_data), .rx_valid(p_rx_valid), .rx_ready(p_rx_ready),
    .rx_parity_err(p_rx_parity_err), .rx_frame_err(p_rx_frame_err), .rx_overrun(p_rx_overrun),
    .err_clr(p_err_clr), .tx_level(p_tx_level), .rx_level(p_rx_level)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Independent line decoder for the 8N1 transmitter: mid-bit sampling, 16 clk per bit.
  int dec_bytes[$];
  int dec_start[$];
  bit dec_en = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (dec_en && tx_out === 1'b0) begin
        int st;
        logic [7:0] b;
        st = cyc;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (16) @(negedge clk);
          b[i] = tx_out;
        end
        repeat (16) @(negedge clk);
        dec_bytes.push_back((tx_out === 1'b1) ? int'(b) : 'h100);
        dec_start.push_back(st);
      end
    end
  end

  task automatic push_tx(input bit which, input logic [7:0] d);
    @(negedge clk);
    if (which) begin p_tx_data = d; p_tx_valid = 1'b1; end
    else begin tx_data = d; tx_valid = 1'b1; end
    @(negedge clk);
    tx_valid   = 1'b0;
    p_tx_valid = 1'b0;
  endtask

  task automatic pop_rx(input bit which, input string tag, input logic [7:0] exp);
    int n = 0;
    @(negedge clk);
    while (!(which ? p_rx_valid : rx_valid) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_valid"}, which ? p_rx_valid : rx_valid, 1);
    check_eq(tag, which ? p_rx_data : rx_data, exp);
    if (which) p_rx_ready = 1'b1; else rx_ready = 1'b1;
    @(negedge clk);
    rx_ready   = 1'b0;
    p_rx_ready = 1'b0;
  endtask

  // Frame built from the line rules: start 0, data LSB first, even parity on the parity instance, stop.
  task automatic send_frame(input bit which, input logic [7:0] d, input bit flip_par, input bit stop0);
    bit bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (which) bits.push_back((^d) ^ flip_par);
    bits.push_back(!stop0);
    foreach (bits[i]) begin
      @(negedge clk);
      if (which) p_rx_drv = bits[i]; else rx_drv = bits[i];
      repeat (15) @(negedge clk);
    end
    @(negedge clk);
    rx_drv   = 1'b1;
    p_rx_drv = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_q[$];
    logic [7:0] d;
    int n;

    baud_div = '0; tx_data = '0; tx_valid = 0; rx_drv = 1; loop = 0; rx_ready = 0; err_clr = 0;
    p_baud_div = '0; p_tx_data = '0; p_tx_valid = 0; p_rx_drv = 1; p_loop = 0; p_rx_ready = 0; p_err_clr = 0;

    repeat (3) @(negedge clk);
    check_eq("rst_tx_out", tx_out, 1);
    check_eq("rst_tx_level", tx_level, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("rst_tx_out_after", tx_out, 1);
    check_eq("rst_tx_ready", tx_ready, 1);
    check_eq("rst_tx_busy", tx_busy, 0);
    check_eq("rst_rx_valid", rx_valid, 0);
    check_eq("rst_rx_data", rx_data, 0);
    check_eq("rst_flags", {rx_parity_err, rx_frame_err, rx_overrun}, 0);
    check_eq("rst_rx_level", rx_level, 0);

    // Loopback: fixed pair then random bytes, gapless frames of 160 clk.
    loop = 1; dec_en = 1;
    exp_q = {8'hA5, 8'h3C};
    repeat (3) exp_q.push_back(8'($urandom_range(0, 255)));
    foreach (exp_q[i]) push_tx(0, exp_q[i]);
    check_eq("lb_tx_busy", tx_busy, 1);
    n = 0;
    while (dec_bytes.size() < exp_q.size() && n < 2000) begin @(negedge clk); n++; end
    check_eq("lb_dec_count", dec_bytes.size(), exp_q.size());
    for (int i = 0; i < dec_bytes.size() && i < exp_q.size(); i++) begin
      check_eq("lb_wire_byte", dec_bytes[i], 32'(exp_q[i]));
      if (i > 0) check_eq("lb_frame_period", dec_start[i] - dec_start[i-1], 160);
    end
    repeat (20) @(negedge clk);
    dec_en = 0;
    check_eq("lb_tx_idle", tx_busy, 0);
    check_eq("lb_rx_level", rx_level, exp_q.size());
    foreach (exp_q[i]) pop_rx(0, "lb_rx_byte", exp_q[i]);
    check_eq("lb_flags", {rx_parity_err, rx_frame_err, rx_overrun}, 0);
    loop = 0;

    // Short low glitch: no push, no flags, receiver ready for the next frame.
    @(negedge clk); rx_drv = 0;
    repeat (4) @(negedge clk); rx_drv = 1;
    repeat (40) @(negedge clk);
    check_eq("glitch_rx_valid", rx_valid, 0);
    check_eq("glitch_flags", {rx_parity_err, rx_frame_err, rx_overrun}, 0);
    d = 8'($urandom_range(0, 255));
    send_frame(0, d, 0, 0);
    pop_rx(0, "glitch_next_byte", d);

    // Stop bit forced low: frame error, byte discarded, clearable.
    send_frame(0, 8'h55, 0, 1);
    check_eq("ferr_flag", rx_frame_err, 1);
    check_eq("ferr_rx_valid", rx_valid, 0);
    check_eq("ferr_other_flags", {rx_parity_err, rx_overrun}, 0);
    @(negedge clk); err_clr = 1;
    @(negedge clk); err_clr = 0;
    check_eq("ferr_cleared", rx_frame_err, 0);
    d = 8'($urandom_range(0, 255));
    send_frame(0, d, 0, 0);
    pop_rx(0, "ferr_next_byte", d);

    // 17 frames with no consumer: FIFO fills, 17th dropped.
    exp_q.delete();
    repeat (17) exp_q.push_back(8'($urandom_range(0, 255)));
    foreach (exp_q[i]) send_frame(0, exp_q[i], 0, 0);
    check_eq("ovr_rx_level", rx_level, 16);
    check_eq("ovr_flag", rx_overrun, 1);
    for (int i = 0; i < 16; i++) pop_rx(0, "ovr_byte", exp_q[i]);
    @(negedge clk);
    check_eq("ovr_drained", rx_valid, 0);
    @(negedge clk); err_clr = 1;
    @(negedge clk); err_clr = 0;
    check_eq("ovr_cleared", rx_overrun, 0);

    // Even parity instance: wire parity bit, loopback, flipped parity, clear.
    p_loop = 1;
    d = 8'h07;
    push_tx(1, d);
    n = 0;
    while (p_tx_out !== 1'b0 && n < 50) begin @(negedge clk); n++; end
    check_eq("par_start_seen", p_tx_out, 0);
    repeat (8 + 16 * 9) @(negedge clk);
    check_eq("par_wire_bit", p_tx_out, ^d);
    pop_rx(1, "par_loop_byte", d);
    check_eq("par_loop_noerr", p_rx_parity_err, 0);
    p_loop = 0;
    send_frame(1, d, 1, 0);
    check_eq("par_flip_err", p_rx_parity_err, 1);
    pop_rx(1, "par_flip_byte", d);
    @(negedge clk); p_err_clr = 1;
    @(negedge clk); p_err_clr = 0;
    check_eq("par_cleared", p_rx_parity_err, 0);
    d = 8'($urandom_range(0, 255));
    send_frame(1, d, 0, 0);
    check_eq("par_rand_noerr", p_rx_parity_err, 0);
    pop_rx(1, "par_rand_byte", d);

    // TX FIFO fill with ticks stalled, then asynchronous resets.
    @(negedge clk); baud_div = 16'hFFFF;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 16; i++) push_tx(0, 8'($urandom_range(0, 255)));
    check_eq("txf_level", tx_level, 16);
    check_eq("txf_ready", tx_ready, 0);
    check_eq("txf_line_idle", tx_out, 1);
    push_tx(0, 8'hFF);
    check_eq("txf_level_17th", tx_level, 16);
    @(negedge clk); reset_n = 0; baud_div = '0;
    #1;
    check_eq("txf_rst_level", tx_level, 0);
    check_eq("txf_rst_ready", tx_ready, 1);
    @(negedge clk); reset_n = 1;
    push_tx(0, 8'h00);
    repeat (60) @(negedge clk);
    check_eq("mid_byte_low", tx_out, 0);
    check_eq("mid_byte_busy", tx_busy, 1);
    #2 reset_n = 0;
    #1;
    check_eq("mid_rst_tx_out", tx_out, 1);
    check_eq("mid_rst_level", tx_level, 0);
    check_eq("mid_rst_busy", tx_busy, 0);
    @(negedge clk); reset_n = 1;
    repeat (5) @(negedge clk);
    check_eq("post_rst_idle", tx_out, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
